// File: rtl/wb_commit_queue_pkg.sv
// Types shared by the writeback commit queue and its bypass matcher.
package wb_commit_queue_pkg;
    `include "defines.svh"

    localparam int WB_DEPTH = 8;

    typedef struct packed {
        REG_ADDR  addr;
        REG_WIDTH data;
    } wb_entry_t;
endpackage

// File: rtl/defines.svh
// Shared scalar types for the register-file datapath.
`ifndef DEFINES_SVH
`define DEFINES_SVH
typedef logic [4:0]  REG_ADDR;
typedef logic [31:0] REG_WIDTH;
typedef logic        bool;
`endif

// File: rtl/wb_fwd_match.sv
// One bypass read port: youngest pending entry whose destination matches addr.
module wb_fwd_match
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wb_entry_t                  ent [DEPTH],
    input  logic [DEPTH-1:0]           vld,
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  REG_ADDR                    addr,
    output bool                        hit,
    output REG_WIDTH                   data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] idx;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - AW'(i);
            if (vld[idx] && ent[idx].addr == addr && addr != '0) begin
                hit  = 1'b1;
                data = ent[idx].data;
            end
        end
    end
endmodule

// File: rtl/wb_commit_queue.sv
// In-order writeback queue: 2-lane push, 2-port regfile drain, 4-port bypass.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 in_valid,
    input  REG_ADDR  [1:0]             in_addr,
    input  REG_WIDTH [1:0]             in_data,
    output logic                       in_ready,
    input  logic                       wb_stall,
    output logic [1:0]                 wr_ena,
    output REG_ADDR  [1:0]             wr_addr,
    output REG_WIDTH [1:0]             wr_data,
    input  REG_ADDR  [3:0]             fwd_addr,
    output logic [3:0]                 fwd_hit,
    output REG_WIDTH [3:0]             fwd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_n;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    cnt_q;

    logic [AW-1:0]    head1;
    logic [AW-1:0]    slot1;
    bool              keep0;
    bool              keep1;
    bool              has1;
    bool              has2;
    bool              same_addr;
    logic [1:0]       n_push;
    logic [1:0]       n_pop;

    assign head1 = head_q + 1'b1;

    always_comb begin
        in_ready = cnt_q <= CW'(DEPTH - 2);
        keep0    = in_valid[0] && in_addr[0] != '0;
        keep1    = in_valid[1] && in_addr[1] != '0;
        slot1    = keep0 ? tail_q + 1'b1 : tail_q;
        n_push   = 2'd0;
        if (in_ready) begin
            n_push = {1'b0, keep0} + {1'b0, keep1};
        end
    end

    // Same-register pair: only the younger write reaches the regfile.
    always_comb begin
        has1       = cnt_q != '0;
        has2       = cnt_q >= CW'(2);
        same_addr  = ent_q[head_q].addr == ent_q[head1].addr;
        wr_addr[0] = ent_q[head_q].addr;
        wr_data[0] = ent_q[head_q].data;
        wr_addr[1] = ent_q[head1].addr;
        wr_data[1] = ent_q[head1].data;
        wr_ena     = 2'b00;
        n_pop      = 2'd0;
        if (!wb_stall) begin
            wr_ena[1] = has2;
            wr_ena[0] = has1 && !(has2 && same_addr);
            n_pop     = has2 ? 2'd2 : (has1 ? 2'd1 : 2'd0);
        end
    end

    // Popped and pushed slots never overlap: pushes need two free slots.
    always_comb begin
        vld_n = vld_q;
        if (n_pop != 2'd0) begin
            vld_n[head_q] = 1'b0;
        end
        if (n_pop == 2'd2) begin
            vld_n[head1] = 1'b0;
        end
        if (in_ready && keep0) begin
            vld_n[tail_q] = 1'b1;
        end
        if (in_ready && keep1) begin
            vld_n[slot1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_n;
            head_q <= head_q + AW'(n_pop);
            tail_q <= tail_q + AW'(n_push);
            cnt_q  <= cnt_q + CW'(n_push) - CW'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && keep0) begin
            ent_q[tail_q] <= '{addr: in_addr[0], data: in_data[0]};
        end
        if (in_ready && keep1) begin
            ent_q[slot1] <= '{addr: in_addr[1], data: in_data[1]};
        end
    end

    assign count = cnt_q;

    for (genvar p = 0; p < 4; p++) begin : g_fwd
        wb_fwd_match #(
            .DEPTH (DEPTH)
        ) u_match (
            .ent   (ent_q),
            .vld   (vld_q),
            .tail  (tail_q),
            .addr  (fwd_addr[p]),
            .hit   (fwd_hit[p]),
            .data  (fwd_data[p])
        );
    end
endmodule
